mem_stage_lsu: RTL and testbench

Load/store unit for the MEM stage of the 5-stage RV32I pipeline, directly upstream of the MEM/WB pipeline register. Takes the EX/MEM address, store data and control, and runs a req/ack transaction with the data memory. It byte-aligns and extends load data into DATA_MEMORY_MEM and stalls the pipeline until the access completes. Misaligned, illegal or timed-out accesses raise lsu_fault instead of touching memory.

---
 rtl/mem_stage_lsu.sv | 181 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit for the RV32I pipeline.
// Runs one req/ack transaction with data memory per load/store, formats
// store lanes and load results, and freezes the pipeline while the access
// is in flight. Misaligned or illegal accesses and ack timeouts raise
// lsu_fault without completing a memory access.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic [2:0]  funct3_MEM,
  input  logic [31:0] ALU_OUT_MEM,
  input  logic [31:0] STORE_DATA_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] DATA_MEMORY_MEM,
  output logic        mem_stall,
  output logic        lsu_fault
);

  localparam logic [31:0] TMO = 32'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic        access, misaligned, bad_f3, illegal, legal_acc;
  logic [1:0]  lane;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] cnt;
  logic        timeout_hit;
  logic        tmo_flag;
  logic        is_load_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] rd_byte_sh, rd_half_sh, ld_fmt;

  // A simultaneous read+write is handled as a store.
  assign access = MemRead_MEM | MemWrite_MEM;
  assign lane   = ALU_OUT_MEM[1:0];

  // Classify the incoming access: size alignment and funct3 legality.
  always_comb begin
    misaligned = 1'b0;
    bad_f3     = 1'b0;
    case (funct3_MEM)
      3'b000:  ;
      3'b001:  misaligned = lane[0];
      3'b010:  misaligned = |lane;
      3'b100:  bad_f3 = MemWrite_MEM;
      3'b101:  begin bad_f3 = MemWrite_MEM; misaligned = lane[0]; end
      default: bad_f3 = 1'b1;
    endcase
  end

  assign illegal   = access & (misaligned | bad_f3);
  assign legal_acc = access & ~illegal;

  // Store lane steering: replicate data across lanes, enable only the target bytes.
  always_comb begin
    be_fmt    = 4'hF;
    wdata_fmt = STORE_DATA_MEM;
    case (funct3_MEM[1:0])
      2'b00: begin
        be_fmt    = 4'b0001 << lane;
        wdata_fmt = {4{STORE_DATA_MEM[7:0]}};
      end
      2'b01: begin
        be_fmt    = 4'b0011 << {lane[1], 1'b0};
        wdata_fmt = {2{STORE_DATA_MEM[15:0]}};
      end
      default: ;
    endcase
  end

  // Load formatting: shift the addressed byte/half to bit 0, then extend.
  always_comb begin
    rd_byte_sh = dmem_rdata >> {lane_q, 3'b000};
    rd_half_sh = dmem_rdata >> {lane_q[1], 4'b0000};
    case (f3_q)
      3'b000:  ld_fmt = {{24{rd_byte_sh[7]}}, rd_byte_sh[7:0]};
      3'b100:  ld_fmt = {24'b0, rd_byte_sh[7:0]};
      3'b001:  ld_fmt = {{16{rd_half_sh[15]}}, rd_half_sh[15:0]};
      3'b101:  ld_fmt = {16'b0, rd_half_sh[15:0]};
      default: ld_fmt = dmem_rdata;
    endcase
  end

  // Abort when this BUSY cycle would be the TIMEOUT_CYC-th without an ack.
  assign timeout_hit = (TMO != 32'd0) && ((cnt + 32'd1) == TMO);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (legal_acc) state_nxt = BUSY;
      BUSY:    if (dmem_ack || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pipeline-facing outputs; both are forced low while reset is held.
  always_comb begin
    mem_stall = 1'b0;
    lsu_fault = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          mem_stall = legal_acc;
          lsu_fault = illegal;
        end
        BUSY:    mem_stall = 1'b1;
        DONE:    lsu_fault = tmo_flag;
        default: ;
      endcase
    end
  end

  // Request fields, timeout counter and load result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= 32'b0;
      dmem_wdata      <= 32'b0;
      dmem_be         <= 4'b0;
      DATA_MEMORY_MEM <= 32'b0;
      cnt             <= 32'b0;
      tmo_flag        <= 1'b0;
      is_load_q       <= 1'b0;
      f3_q            <= 3'b0;
      lane_q          <= 2'b0;
    end else begin
      case (state)
        IDLE: begin
          if (legal_acc) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite_MEM;
            dmem_addr  <= {ALU_OUT_MEM[31:2], 2'b00};
            dmem_wdata <= wdata_fmt;
            dmem_be    <= be_fmt;
            is_load_q  <= ~MemWrite_MEM;
            f3_q       <= funct3_MEM;
            lane_q     <= lane;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (is_load_q) DATA_MEMORY_MEM <= ld_fmt;
          end else if (timeout_hit) begin
            dmem_req <= 1'b0;
            tmo_flag <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        DONE: begin
          cnt      <= 32'b0;
          tmo_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: each access pushes its expected
// outcome, a simple memory responder acks after a chosen delay, and the
// outcome is popped and compared when the stall releases.
module tb_mem_stage_lsu;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead_MEM, MemWrite_MEM;
  logic [2:0]  funct3_MEM;
  logic [31:0] ALU_OUT_MEM, STORE_DATA_MEM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] DATA_MEMORY_MEM;
  logic        mem_stall, lsu_fault;

  mem_stage_lsu #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
    .funct3_MEM(funct3_MEM), .ALU_OUT_MEM(ALU_OUT_MEM), .STORE_DATA_MEM(STORE_DATA_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .DATA_MEMORY_MEM(DATA_MEMORY_MEM),
    .mem_stall(mem_stall), .lsu_fault(lsu_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        legal;
    logic        fault;
    logic        is_ld;
    logic [31:0] dm;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    int          stalls;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] dm_model = 32'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic legal_f(input logic rd, input logic wr, input logic [2:0] f3, input logic [1:0] a);
    if (!(rd | wr)) return 1'b0;
    if (wr) begin
      case (f3)
        3'b000:  return 1'b1;
        3'b001:  return a[0] == 1'b0;
        3'b010:  return a == 2'b00;
        default: return 1'b0;
      endcase
    end
    case (f3)
      3'b000, 3'b100: return 1'b1;
      3'b001, 3'b101: return a[0] == 1'b0;
      3'b010:         return a == 2'b00;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic signed [31:0] t;
    int sh;
    case (f3)
      3'b000: begin sh = 24 - 8 * int'(a); t = w << sh; return t >>> 24; end
      3'b100: return (w >> (8 * int'(a))) & 32'hFF;
      3'b001: begin sh = a[1] ? 0 : 16; t = w << sh; return t >>> 16; end
      3'b101: return (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] be_model(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   case (a) 2'd0: return 4'b0001; 2'd1: return 4'b0010; 2'd2: return 4'b0100; default: return 4'b1000; endcase
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wd_model(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01:   return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  // One pipeline access; delay = BUSY cycles without ack before the ack.
  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input int delay, input logic [31:0] word);
    exp_t        e, g;
    int          stalls = 0, waited = 0, cyc = 0;
    logic        req_seen = 1'b0, fault_mid = 1'b0, fault_end;
    logic [31:0] c_addr = 0, c_wdata = 0;
    logic [3:0]  c_be = 0;
    logic        c_we = 0;
    logic        tmo;

    e.tag   = tag;
    e.legal = legal_f(rd, wr, f3, a[1:0]);
    tmo     = e.legal && (delay >= TMO);
    e.fault = ((rd | wr) && !e.legal) || tmo;
    e.is_ld = rd & ~wr;
    if (e.legal && e.is_ld && !tmo) dm_model = ld_model(f3, a[1:0], word);
    e.dm     = dm_model;
    e.addr   = {a[31:2], 2'b00};
    e.we     = wr;
    e.be     = be_model(f3, a[1:0]);
    e.wdata  = wd_model(f3, d);
    e.stalls = !e.legal ? 0 : 1 + (tmo ? TMO : delay + 1);
    sbq.push_back(e);

    @(negedge clk);
    MemRead_MEM = rd; MemWrite_MEM = wr; funct3_MEM = f3;
    ALU_OUT_MEM = a; STORE_DATA_MEM = d;
    #1;
    while (1) begin
      if (!mem_stall) break;
      if (lsu_fault) fault_mid = 1'b1;
      stalls++;
      if (dmem_req) begin
        req_seen = 1'b1;
        c_addr = dmem_addr; c_wdata = dmem_wdata; c_be = dmem_be; c_we = dmem_we;
        if (waited == delay) begin dmem_ack = 1'b1; dmem_rdata = word; end
        else begin dmem_ack = 1'b0; waited++; end
      end else begin
        dmem_ack = 1'b0;
      end
      cyc++;
      if (cyc > 100) begin
        chk({tag, ".bound"}, 32'd1, 32'd0);
        break;
      end
      @(negedge clk); #1;
    end
    fault_end = lsu_fault;
    MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0; dmem_ack = 1'b0;

    g = sbq.pop_front();
    chk({g.tag, ".stalls"}, 32'(stalls), 32'(g.stalls));
    chk({g.tag, ".fault"}, {31'b0, fault_end}, {31'b0, g.fault});
    chk({g.tag, ".fault_mid"}, {31'b0, fault_mid}, 32'd0);
    chk({g.tag, ".req_seen"}, {31'b0, req_seen}, {31'b0, g.legal});
    chk({g.tag, ".data"}, DATA_MEMORY_MEM, g.dm);
    if (g.legal) begin
      chk({g.tag, ".addr"}, c_addr, g.addr);
      chk({g.tag, ".we"}, {31'b0, c_we}, {31'b0, g.we});
      if (!g.is_ld) begin
        chk({g.tag, ".be"}, {28'b0, c_be}, {28'b0, g.be});
        chk({g.tag, ".wdata"}, c_wdata, g.wdata);
      end
    end
    @(negedge clk); #1;
    chk({g.tag, ".post_fault"}, {31'b0, lsu_fault}, 32'd0);
    chk({g.tag, ".post_stall"}, {31'b0, mem_stall}, 32'd0);
    chk({g.tag, ".post_req"}, {31'b0, dmem_req}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    MemRead_MEM = 0; MemWrite_MEM = 0; funct3_MEM = 0;
    ALU_OUT_MEM = 0; STORE_DATA_MEM = 0; dmem_rdata = 0; dmem_ack = 0;
    @(negedge clk); #1;
    chk("rst.stall", {31'b0, mem_stall}, 32'd0);
    @(negedge clk); #1;
    chk("rst.req", {31'b0, dmem_req}, 32'd0);
    chk("rst.we", {31'b0, dmem_we}, 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk("rst.be", {28'b0, dmem_be}, 32'd0);
    chk("rst.data", DATA_MEMORY_MEM, 32'd0);
    chk("rst.fault", {31'b0, lsu_fault}, 32'd0);
    reset = 1'b0;

    access("lb",   1, 0, 3'b000, 32'h101, 0, 0, 32'h8899AABB);
    access("lbu",  1, 0, 3'b100, 32'h101, 0, 0, 32'h8899AABB);
    access("lh",   1, 0, 3'b001, 32'h102, 0, 0, 32'h8899AABB);
    access("lhu",  1, 0, 3'b101, 32'h102, 0, 0, 32'h8899AABB);
    access("lw",   1, 0, 3'b010, 32'h100, 0, 1, 32'h8899AABB);
    access("sb",   0, 1, 3'b000, 32'h103, 32'h12345678, 0, 32'hDEADBEEF);
    access("sh",   0, 1, 3'b001, 32'h102, 32'h12345678, 2, 32'hDEADBEEF);
    access("lw_mis", 1, 0, 3'b010, 32'h102, 0, 0, 32'h0);
    access("sh_mis", 0, 1, 3'b001, 32'h101, 32'h1, 0, 32'h0);
    access("ld_f3",  1, 0, 3'b011, 32'h100, 0, 0, 32'h0);
    access("st_f3",  0, 1, 3'b100, 32'h100, 32'h5, 0, 32'h0);
    access("tmo",    1, 0, 3'b010, 32'h100, 0, 999, 32'h55555555);
    access("wait3",  1, 0, 3'b010, 32'h104, 0, 3, 32'h11223344);
    access("rdwr",   1, 1, 3'b010, 32'h108, 32'hCAFEF00D, 0, 32'h77777777);
    access("nop",    0, 0, 3'b010, 32'h10C, 0, 0, 32'h0);
    access("lb_pos", 1, 0, 3'b000, 32'h200, 0, 0, 32'h1234567F);

    for (int i = 0; i < 6; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      case ($urandom_range(0, 4))
        0: f3 = 3'b000; 1: f3 = 3'b100; 2: f3 = 3'b001; 3: f3 = 3'b101; default: f3 = 3'b010;
      endcase
      a = 32'h300 | 32'($urandom_range(0, 3));
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3 == 3'b010) a[1:0] = 2'b00;
      access("rnd_ld", 1, 0, f3, a, 0, int'($urandom_range(0, 2)), $urandom);
    end

    // Reset in the second BUSY cycle aborts the access; a late ack is ignored.
    @(negedge clk);
    MemRead_MEM = 1; funct3_MEM = 3'b010; ALU_OUT_MEM = 32'h100;
    #1 chk("mid.idle_stall", {31'b0, mem_stall}, 32'd1);
    @(negedge clk); #1;
    chk("mid.busy1_req", {31'b0, dmem_req}, 32'd1);
    @(negedge clk); #1;
    reset = 1'b1; MemRead_MEM = 0;
    #1 chk("mid.rst_stall", {31'b0, mem_stall}, 32'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    chk("mid.req", {31'b0, dmem_req}, 32'd0);
    chk("mid.stall", {31'b0, mem_stall}, 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'hA5A5A5A5;
    @(negedge clk); #1;
    dmem_ack = 1'b0;
    dm_model = 32'b0;
    chk("mid.late_ack_data", DATA_MEMORY_MEM, 32'd0);
    chk("mid.late_ack_req", {31'b0, dmem_req}, 32'd0);
    chk("mid.late_ack_stall", {31'b0, mem_stall}, 32'd0);
    access("after_rst", 1, 0, 3'b100, 32'h102, 0, 1, 32'h00C30000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
